// File: rtl/gba_bus_arbiter_pkg.sv
// Shared types for the GBA bus arbiter: bus word, memory regions,
// bus owner and the arbiter FSM state.
package types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      BIOS,
      EWRAM,
      IWRAM,
      IO,
      PAL,
      VRAM,
      OAM,
      ROM,
      SRAM,
      UNMAPPED
   } region_e;

   typedef enum logic {
      OWNER_CPU,
      OWNER_DMA
   } bus_owner_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } arb_state_e;

endpackage

// File: rtl/gba_bus_arbiter_if.sv
// Simple memory bus: addr, wdata, read_en, write_en toward the slave,
// rdata back. Master_side drives the request, Slave_side answers it.
interface Bus_if;
   import types_pkg::*;

   word_t addr;
   word_t wdata;
   word_t rdata;
   logic  read_en;
   logic  write_en;

   modport Master_side (
      output addr,
      output wdata,
      output read_en,
      output write_en,
      input  rdata
   );

   modport Slave_side (
      input  addr,
      input  wdata,
      input  read_en,
      input  write_en,
      output rdata
   );

endinterface

// File: rtl/gba_bus_arbiter_region_decode.sv
// Region decode: maps addr[27:24] to a GBA memory region and its
// wait-state count. Ports: sel in, region out, wait_cnt out.
module gba_region_decode
   import types_pkg::*;
#(
   parameter int WS_BIOS  = 0,
   parameter int WS_EWRAM = 2,
   parameter int WS_IWRAM = 0,
   parameter int WS_ROM   = 4,
   parameter int WS_SRAM  = 4
)(
   input  logic [3:0] sel,
   output region_e    region,
   output logic [3:0] wait_cnt
);

   always_comb begin
      region = UNMAPPED;
      unique case (sel)
         4'h0:    region = BIOS;
         4'h2:    region = EWRAM;
         4'h3:    region = IWRAM;
         4'h4:    region = IO;
         4'h5:    region = PAL;
         4'h6:    region = VRAM;
         4'h7:    region = OAM;
         4'h8, 4'h9, 4'hA,
         4'hB, 4'hC, 4'hD:
                  region = ROM;
         4'hE:    region = SRAM;
         default: region = UNMAPPED;
      endcase
   end

   always_comb begin
      wait_cnt = 4'(WS_SRAM);
      unique case (region)
         BIOS:    wait_cnt = 4'(WS_BIOS);
         EWRAM:   wait_cnt = 4'(WS_EWRAM);
         IWRAM, IO, PAL, VRAM, OAM:
                  wait_cnt = 4'(WS_IWRAM);
         ROM:     wait_cnt = 4'(WS_ROM);
         default: wait_cnt = 4'(WS_SRAM);
      endcase
   end

endmodule

// File: rtl/gba_bus_arbiter.sv
// CPU/DMA arbiter for the GBA system bus with per-region wait states.
// Ports: clk, reset (sync, active-high); cpu_bus, dma_bus (Slave_side)
// requesters; mem_bus (Master_side) to the MMU; cpu_ready, dma_ready
// one-cycle completion strobes; dma_lock keeps the bus with DMA.
// Macro GBA_BUS_ARB_WAITSTATE_EN enables region wait states; when
// undefined every access completes 2 cycles after grant.
module gba_bus_arbiter
   import types_pkg::*;
#(
   parameter int WS_BIOS  = 0,
   parameter int WS_EWRAM = 2,
   parameter int WS_IWRAM = 0,
   parameter int WS_ROM   = 4,
   parameter int WS_SRAM  = 4
)(
   input  logic       clk,
   input  logic       reset,
   Bus_if.Slave_side  cpu_bus,
   Bus_if.Slave_side  dma_bus,
   Bus_if.Master_side mem_bus,
   output logic       cpu_ready,
   output logic       dma_ready,
   input  logic       dma_lock
);

   arb_state_e state_q;
   arb_state_e state_d;
   bus_owner_e owner_q;
   word_t      addr_q;
   word_t      wdata_q;
   logic       wr_q;
   logic       lock_q;
   logic [3:0] wcnt_q;

   logic       cpu_pend;
   logic       dma_pend;
   logic       hold;
   logic       go;
   word_t      sel_addr;
   word_t      sel_wdata;
   logic       sel_wr;
   logic [3:0] sel_wcnt;

   assign cpu_pend = cpu_bus.read_en | cpu_bus.write_en;
   assign dma_pend = dma_bus.read_en | dma_bus.write_en;

   // A locked DMA burst keeps the CPU out even while DMA
   // briefly has no request between its accesses.
   assign hold = lock_q & dma_lock;
   assign go   = dma_pend | (cpu_pend & ~hold);

   assign sel_addr  = dma_pend ? dma_bus.addr  : cpu_bus.addr;
   assign sel_wdata = dma_pend ? dma_bus.wdata : cpu_bus.wdata;
   assign sel_wr    = dma_pend ? dma_bus.write_en
                               : cpu_bus.write_en;

`ifdef GBA_BUS_ARB_WAITSTATE_EN
   gba_region_decode #(
      .WS_BIOS  (WS_BIOS),
      .WS_EWRAM (WS_EWRAM),
      .WS_IWRAM (WS_IWRAM),
      .WS_ROM   (WS_ROM),
      .WS_SRAM  (WS_SRAM)
   ) u_decode (
      .sel      (sel_addr[27:24]),
      .region   (),
      .wait_cnt (sel_wcnt)
   );
`else
   assign sel_wcnt = 4'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (go) state_d = ST_ACCESS;
         ST_ACCESS: if (wcnt_q == 4'd0) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWNER_CPU;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         lock_q  <= 1'b0;
         wcnt_q  <= 4'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               lock_q <= hold;
               if (go) begin
                  owner_q <= dma_pend ? OWNER_DMA : OWNER_CPU;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  wr_q    <= sel_wr;
                  wcnt_q  <= sel_wcnt;
                  lock_q  <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
            end
            ST_DONE: begin
               lock_q <= (owner_q == OWNER_DMA) & dma_lock;
            end
            default: ;
         endcase
      end
   end

   // Outputs are gated by reset so an access cut short by reset
   // never shows a write or ready strobe.
   always_comb begin
      mem_bus.addr     = '0;
      mem_bus.wdata    = '0;
      mem_bus.read_en  = 1'b0;
      mem_bus.write_en = 1'b0;
      cpu_bus.rdata    = '0;
      dma_bus.rdata    = '0;
      cpu_ready        = 1'b0;
      dma_ready        = 1'b0;
      if (!reset && state_q != ST_IDLE) begin
         mem_bus.addr    = addr_q;
         mem_bus.wdata   = wdata_q;
         mem_bus.read_en = ~wr_q;
         if (state_q == ST_DONE) begin
            mem_bus.write_en = wr_q;
            if (owner_q == OWNER_DMA) begin
               dma_ready = 1'b1;
               if (!wr_q) dma_bus.rdata = mem_bus.rdata;
            end else begin
               cpu_ready = 1'b1;
               if (!wr_q) cpu_bus.rdata = mem_bus.rdata;
            end
         end
      end
   end

endmodule
